// File: rtl/spi_burst_reader.sv
// Burst reader: turns a word-count read request into per-word flash controller
// transactions. Build option: define SPI_BURST_BYTESWAP_EN to byte-reverse read data.
module spi_burst_reader #(
  parameter logic [7:0] CMD_READ  = 8'h0B,
  parameter logic [3:0] DUMMY_CYC = 4'd8,
  parameter logic [2:0] COMMTYPE  = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_nwords,
  input  logic        req_4byte,
  input  logic        abort,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        busy,
  output logic        m_validflag,
  input  logic        m_tready,
  output logic [31:0] m_address,
  output logic [7:0]  m_command,
  output logic [2:0]  m_commtype,
  output logic [6:0]  m_ndata_bits,
  output logic [3:0]  m_dummy_cycles,
  output logic        m_fourbyteaddr_on,
  input  logic [31:0] m_data_out
);

  // state     | meaning
  // IDLE      | waiting for a burst request
  // ISSUE     | presenting one word transaction to the controller
  // WAIT_LOW  | transaction accepted, waiting for controller to go busy
  // WAIT_DONE | controller busy, waiting for it to finish the word
  // OUT       | holding the word on the response stream
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_DONE, OUT} state_t;

  state_t      state, state_nx;
  logic [31:0] addr_q;
  logic [4:0]  left_q;
  logic        four_q;
  logic        abort_q;
  logic [31:0] data_q;
  logic        last_q;

  logic        abort_now;
  logic [4:0]  nwords_clamped;
  logic [31:0] addr_next;
  logic [31:0] data_in;

  assign abort_now      = abort_q | abort;
  assign nwords_clamped = (req_nwords == 5'd0 || req_nwords > 5'd16) ? 5'd16 : req_nwords;
  // 3-byte mode wraps inside the 16 MiB window and keeps the top byte clear
  assign addr_next      = four_q ? addr_q + 32'd4 : {8'h00, addr_q[23:0] + 24'd4};

`ifdef SPI_BURST_BYTESWAP_EN
  assign data_in = {m_data_out[7:0], m_data_out[15:8], m_data_out[23:16], m_data_out[31:24]};
`else
  assign data_in = m_data_out;
`endif

  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    busy        = 1'b1;
    m_validflag = 1'b0;
    rsp_valid   = 1'b0;
    rsp_last    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nx = ISSUE;
      end
      ISSUE: begin
        // an abort withdraws the request before the controller can take it
        m_validflag = ~abort_now;
        if (abort_now)     state_nx = IDLE;
        else if (m_tready) state_nx = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!m_tready) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (m_tready) state_nx = OUT;
      end
      OUT: begin
        rsp_valid = 1'b1;
        rsp_last  = last_q;
        if (rsp_ready) state_nx = (last_q || abort_now) ? IDLE : ISSUE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= 32'd0;
      left_q  <= 5'd0;
      four_q  <= 1'b0;
      abort_q <= 1'b0;
      data_q  <= 32'd0;
      last_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE)  abort_q <= 1'b0;
      else if (abort)     abort_q <= 1'b1;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_4byte ? req_addr : {8'h00, req_addr[23:0]};
            left_q <= nwords_clamped;
            four_q <= req_4byte;
          end
        end
        WAIT_DONE: begin
          if (m_tready) begin
            data_q <= data_in;
            last_q <= (left_q == 5'd1) || abort_now;
          end
        end
        OUT: begin
          if (rsp_ready) begin
            addr_q <= addr_next;
            left_q <= left_q - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_data          = data_q;
  assign m_address         = addr_q;
  assign m_fourbyteaddr_on = four_q;
  assign m_command         = CMD_READ;
  assign m_commtype        = COMMTYPE;
  assign m_ndata_bits      = 7'd32;
  assign m_dummy_cycles    = DUMMY_CYC;

endmodule

// File: tb/tb_spi_burst_reader.sv
// Self-checking bench for spi_burst_reader: a directed vector table, hand-written
// reset/abort sequences and randomized bursts checked against a behavioural model.
module tb_spi_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [4:0]  req_nwords;
  logic        req_4byte;
  logic        abort;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_data;
  logic        busy;
  logic        m_validflag, m_tready;
  logic [31:0] m_address;
  logic [7:0]  m_command;
  logic [2:0]  m_commtype;
  logic [6:0]  m_ndata_bits;
  logic [3:0]  m_dummy_cycles;
  logic        m_fourbyteaddr_on;
  logic [31:0] m_data_out;

  always #5 clk = ~clk;

  spi_burst_reader dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_nwords(req_nwords), .req_4byte(req_4byte), .abort(abort),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy),
    .m_validflag(m_validflag), .m_tready(m_tready), .m_address(m_address),
    .m_command(m_command), .m_commtype(m_commtype), .m_ndata_bits(m_ndata_bits),
    .m_dummy_cycles(m_dummy_cycles), .m_fourbyteaddr_on(m_fourbyteaddr_on),
    .m_data_out(m_data_out)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] addr_log[$];
  bit          ctl_stall = 1'b0;
  bit          ctl_fixed_en = 1'b0;
  logic [31:0] ctl_fixed_data = 32'd0;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  nw;
    bit          four;
    int          abort_word;
    int          bp;
    bit          use_fixed;
    logic [31:0] fixed;
    int          exp_words;
    logic [31:0] exp_last;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // content the fake flash holds at a given byte address
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0F1E_2D3C;
  endfunction

  function automatic logic [31:0] expect_data(input logic [31:0] d);
    logic [31:0] r;
    r = d;
`ifdef SPI_BURST_BYTESWAP_EN
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(3-i) +: 8];
`endif
    return r;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input bit four);
    longint s;
    s = longint'(a) + 64'd4;
    if (four) s = s % 64'h1_0000_0000;
    else      s = s % 64'h100_0000;
    return s[31:0];
  endfunction

  function automatic int clamp_words(input logic [4:0] nw);
    return (nw == 5'd0 || nw > 5'd16) ? 16 : int'(nw);
  endfunction

  // flash controller model: accept, go busy for a random time, return a word
  initial begin
    int          phase;
    int          low;
    bit          chk_lat;
    logic [31:0] cur;
    phase = 0; low = 0; chk_lat = 1'b0; cur = 32'd0;
    m_tready = 1'b1;
    m_data_out = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0; chk_lat = 1'b0; m_tready = 1'b1;
      end else begin
        case (phase)
          0: begin
            if (chk_lat) begin
              chk("rsp_latency", {31'd0, rsp_valid}, 32'd1);
              chk_lat = 1'b0;
            end
            m_tready = !ctl_stall;
            if (m_validflag && !ctl_stall) begin
              addr_log.push_back(m_address);
              cur = m_address;
              phase = 1;
            end
          end
          1: begin
            m_tready = 1'b0;
            low = $urandom_range(0, 3);
            phase = 2;
          end
          default: begin
            if (low == 0) begin
              m_tready = 1'b1;
              m_data_out = ctl_fixed_en ? ctl_fixed_data : data_of(cur);
              chk_lat = 1'b1;
              phase = 0;
            end else begin
              low--;
            end
          end
        endcase
      end
    end
  end

  task automatic run_burst(input logic [31:0] a, input logic [4:0] nw, input bit four,
                           input int abort_word, input int bp,
                           output int seen, output logic [31:0] last_addr);
    int          n;
    int          t;
    logic [31:0] ea;
    logic [31:0] got;
    logic [31:0] src;
    n = clamp_words(nw);
    if (abort_word > 0 && abort_word < n) n = abort_word;
    ea = four ? a : (a % 32'h0100_0000);
    seen = 0;
    last_addr = 32'hDEAD_BEEF;
    tick();
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    req_addr = a; req_nwords = nw; req_4byte = four; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("validflag_latency", {31'd0, m_validflag}, 32'd1);
    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    chk("m_fourbyte", {31'd0, m_fourbyteaddr_on}, {31'd0, four});
    chk("m_command", {24'd0, m_command}, 32'h0B);
    chk("m_commtype", {29'd0, m_commtype}, 32'd2);
    chk("m_ndata_bits", {25'd0, m_ndata_bits}, 32'd32);
    chk("m_dummy", {28'd0, m_dummy_cycles}, 32'd8);
    for (int w = 1; w <= n; w++) begin
      if (w == abort_word) begin
        t = 0;
        while (addr_log.size() == 0 && t < 100) begin @(negedge clk); t++; end
        tick(); abort = 1'b1;
        tick(); abort = 1'b0;
      end
      t = 0;
      while (rsp_valid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin
        chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
        return;
      end
      chk("addr_log_depth", addr_log.size(), 32'd1);
      got = (addr_log.size() > 0) ? addr_log.pop_front() : 32'hFFFF_FFFF;
      chk("m_address", got, ea);
      src = ctl_fixed_en ? ctl_fixed_data : data_of(ea);
      chk("rsp_data", rsp_data, expect_data(src));
      chk("rsp_last", {31'd0, rsp_last}, {31'd0, (w == n)});
      for (int c = 0; c < bp; c++) begin
        @(negedge clk);
        chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_data", rsp_data, expect_data(src));
        chk("bp_validflag", {31'd0, m_validflag}, 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      seen++;
      last_addr = got;
      ea = next_addr(ea, four);
    end
    repeat (4) @(negedge clk);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("no_extra_issue", addr_log.size(), 32'd0);
    chk("rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int          seen;
    int          nexp;
    int          ab;
    logic [31:0] la;
    logic [31:0] ra;
    logic [4:0]  rn;
    bit          rf;

    vecs[0] = '{32'h0000_0100, 5'd1,  1'b0, 0, 0,  1'b1, 32'hA5A5_1234, 1,  32'h0000_0100};
    vecs[1] = '{32'h0000_00F0, 5'd4,  1'b0, 0, 0,  1'b0, 32'd0,         4,  32'h0000_00FC};
    vecs[2] = '{32'h00FF_FFFC, 5'd2,  1'b0, 0, 0,  1'b0, 32'd0,         2,  32'h0000_0000};
    vecs[3] = '{32'h00FF_FFFC, 5'd2,  1'b1, 0, 0,  1'b0, 32'd0,         2,  32'h0100_0000};
    vecs[4] = '{32'h0000_0200, 5'd1,  1'b0, 0, 10, 1'b0, 32'd0,         1,  32'h0000_0200};
    vecs[5] = '{32'h0000_1000, 5'd8,  1'b0, 2, 0,  1'b0, 32'd0,         2,  32'h0000_1004};
    vecs[6] = '{32'h0000_0000, 5'd0,  1'b0, 0, 0,  1'b0, 32'd0,         16, 32'h0000_003C};
    vecs[7] = '{32'h0000_0040, 5'd20, 1'b1, 0, 1,  1'b0, 32'd0,         16, 32'h0000_007C};
    vecs[8] = '{32'h0000_0300, 5'd1,  1'b0, 0, 0,  1'b1, 32'h1122_3344, 1,  32'h0000_0300};
    vecs[9] = '{32'hAB12_3456, 5'd3,  1'b0, 0, 2,  1'b0, 32'd0,         3,  32'h0012_345E};

    rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'd0; req_nwords = 5'd0; req_4byte = 1'b0;
    abort = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_validflag", {31'd0, m_validflag}, 32'd0);
    chk("rst_m_address", m_address, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      ctl_fixed_en = vecs[i].use_fixed;
      ctl_fixed_data = vecs[i].fixed;
      run_burst(vecs[i].addr, vecs[i].nw, vecs[i].four, vecs[i].abort_word, vecs[i].bp, seen, la);
      chk($sformatf("vec%0d_words", i), seen, vecs[i].exp_words);
      chk($sformatf("vec%0d_last_addr", i), la, vecs[i].exp_last);
    end
    ctl_fixed_en = 1'b0;

    // abort while idle must not affect the next burst
    abort = 1'b1;
    repeat (3) tick();
    chk("idle_abort_busy", {31'd0, busy}, 32'd0);
    abort = 1'b0;
    run_burst(32'h0000_0800, 5'd2, 1'b0, 0, 0, seen, la);
    chk("idle_abort_words", seen, 32'd2);

    // abort while the request is still waiting for the controller
    ctl_stall = 1'b1;
    tick();
    req_addr = 32'h0000_0900; req_nwords = 5'd4; req_4byte = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("issue_validflag", {31'd0, m_validflag}, 32'd1);
    abort = 1'b1;
    #1;
    chk("issue_abort_drop", {31'd0, m_validflag}, 32'd0);
    tick();
    abort = 1'b0;
    ctl_stall = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("issue_abort_idle", {31'd0, busy}, 32'd0);
      chk("issue_abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    chk("issue_abort_no_tx", addr_log.size(), 32'd0);

    // reset in the middle of a burst
    tick();
    req_addr = 32'h0000_0500; req_nwords = 5'd4; req_4byte = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_rsp_data", rsp_data, 32'd0);
    chk("mid_rst_validflag", {31'd0, m_validflag}, 32'd0);
    chk("mid_rst_m_address", m_address, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    rst = 1'b0;
    addr_log.delete();
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("post_rst_idle", {31'd0, busy}, 32'd0);
    end

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rn = 5'($urandom_range(0, 31));
      rf = 1'($urandom_range(0, 1));
      nexp = clamp_words(rn);
      ab = 0;
      if ($urandom_range(0, 3) == 0 && nexp > 1) begin
        ab = int'($urandom_range(1, nexp - 1));
        nexp = ab;
      end
      run_burst(ra, rn, rf, ab, int'($urandom_range(0, 3)), seen, la);
      chk("rand_words", seen, nexp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
